io_responder: RTL and testbench

- MMIO responder on the device side of the core's single IO port; the core's IoRead/IoWrite strobes target this block.
- Services core IO writes by latching the LED register. Acknowledges on a one-cycle ready handshake.
- Services core IO reads by stalling until the user presses a debounced confirm button, then returning the synchronized switch value.

---
 rtl/io_responder_if.sv | 22 ++
 rtl/io_responder.sv | 133 +++++++++++++
 tb/tb_io_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/io_responder_if.sv
// Core-side IO port bundle: level read/write strobes from the core, one-cycle
// ready pulse, busy stall indication and read data back from the responder.
interface io_responder_if #(
    parameter int DATA_W = 32
);
    logic              io_read;
    logic              io_write;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_ready;
    logic              io_busy;

    modport master (
        output io_read, io_write, io_wdata,
        input  io_rdata, io_ready, io_busy
    );

    modport slave (
        input  io_read, io_write, io_wdata,
        output io_rdata, io_ready, io_busy
    );
endinterface

// File: rtl/io_responder.sv
// MMIO responder: writes latch the LED register, reads stall until a fresh
// debounced confirm-button press and then return the synchronized switches.
module io_responder #(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int LED_W           = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    io_responder_if.slave    bus,
    input  logic [SW_W-1:0]  sw_in,
    input  logic             btn_confirm,
    output logic [LED_W-1:0] led_out,
    output logic             wait_led
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [SW_W-1:0]   sw_meta_r;
    logic [SW_W-1:0]   sw_sync_r;
    logic              btn_meta_r;
    logic              btn_sync_r;
    logic [CNT_W-1:0]  db_cnt_r;
    logic              btn_db_r;
    logic              btn_db_q_r;
    logic              btn_rise_s;
    logic [DATA_W-1:0] sw_ext_s;
    logic [DATA_W-1:0] rdata_r;
    logic [LED_W-1:0]  led_r;
    logic              ready_r;
    logic              busy_r;
    logic              wait_led_r;

    // Two-flop synchronizers for the asynchronous switches and button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r  <= '0;
            sw_sync_r  <= '0;
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            sw_meta_r  <= sw_in;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= btn_confirm;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce: the level only follows after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r   <= '0;
            btn_db_r   <= 1'b0;
            btn_db_q_r <= 1'b0;
        end else begin
            btn_db_q_r <= btn_db_r;
            if (btn_sync_r == btn_db_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_r <= '0;
                btn_db_r <= btn_sync_r;
            end else begin
                db_cnt_r <= db_cnt_r + CNT_W'(1);
            end
        end
    end

    // Rise detect and zero-extended switch value for read data.
    always_comb begin
        btn_rise_s            = btn_db_r & ~btn_db_q_r;
        sw_ext_s              = '0;
        sw_ext_s[SW_W-1:0]    = sw_sync_r;
    end

    // Next-state logic; write wins over a simultaneous read.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.io_write) begin
                    state_nx_s = WR_RESP;
                end else if (bus.io_read) begin
                    state_nx_s = RD_WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WR_RESP: state_nx_s = IDLE;
            RD_WAIT: begin
                if (btn_rise_s) begin
                    state_nx_s = RD_RESP;
                end else begin
                    state_nx_s = RD_WAIT;
                end
            end
            RD_RESP: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            wait_led_r <= 1'b0;
            led_r      <= '0;
            rdata_r    <= '0;
        end else begin
            state_r    <= state_nx_s;
            ready_r    <= (state_nx_s == WR_RESP) || (state_nx_s == RD_RESP);
            busy_r     <= (state_nx_s == RD_WAIT);
            wait_led_r <= (state_nx_s == RD_WAIT);
            if ((state_r == IDLE) && bus.io_write) begin
                led_r <= bus.io_wdata[LED_W-1:0];
            end
            if ((state_r == RD_WAIT) && btn_rise_s) begin
                rdata_r <= sw_ext_s;
            end
        end
    end

    assign bus.io_rdata = rdata_r;
    assign bus.io_ready = ready_r;
    assign bus.io_busy  = busy_r;
    assign led_out      = led_r;
    assign wait_led     = wait_led_r;
endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus pushes expected completions,
// a negedge monitor pops and compares on every io_ready pulse.
module tb_io_responder;
    logic        clk;
    logic        rst_n;
    logic [15:0] sw_in;
    logic        btn_confirm;
    logic [15:0] led_out;
    logic        wait_led;

    io_responder_if #(.DATA_W(32)) bus ();

    io_responder #(
        .DATA_W(32), .SW_W(16), .LED_W(16), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .sw_in(sw_in),
        .btn_confirm(btn_confirm), .led_out(led_out), .wait_led(wait_led)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] led;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.io_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 expected none");
            end else begin
                e = sb_q.pop_front();
                chk("rdata", bus.io_rdata, e.rdata);
                chk("led", {16'h0000, led_out}, {16'h0000, e.led});
                chk("busy_at_ready", {31'h0, bus.io_busy}, 32'h0);
                chk("wait_led_at_ready", {31'h0, wait_led}, 32'h0);
            end
        end
    end

    task automatic wait_ready(input int maxc, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            n++;
            if (bus.io_ready) begin
                ok = 1'b1;
                bus.io_read  = 1'b0;
                bus.io_write = 1'b0;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready in %0d cycles expected ready", maxc);
            bus.io_read  = 1'b0;
            bus.io_write = 1'b0;
        end
    endtask

    task automatic press(input int n);
        btn_confirm = 1'b1;
        repeat (n) @(negedge clk);
        btn_confirm = 1'b0;
    endtask

    logic [31:0] m_rdata;
    logic [15:0] m_led;
    int          n;

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        sw_in        = 16'h0000;
        btn_confirm  = 1'b0;
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.io_wdata = 32'h0;
        m_rdata      = 32'h0;
        m_led        = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.io_rdata, 32'h0);
        chk("rst_ready", {31'h0, bus.io_ready}, 32'h0);
        chk("rst_busy", {31'h0, bus.io_busy}, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_wait_led", {31'h0, wait_led}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write: one-cycle latency to both LEDs and ready.
        m_led = 16'hA5C3;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        bus.io_write = 1'b1;
        bus.io_wdata = 32'h0001_A5C3;
        wait_ready(10, n);
        chk("write_latency", n, 32'd1);
        @(negedge clk);
        chk("write_no_busy", {31'h0, bus.io_busy}, 32'h0);

        // Read completed by a clean press.
        sw_in = 16'h1234;
        repeat (4) @(negedge clk);
        bus.io_read = 1'b1;
        @(negedge clk);
        chk("read_busy", {31'h0, bus.io_busy}, 32'h1);
        chk("read_wait_led", {31'h0, wait_led}, 32'h1);
        m_rdata = 32'h0000_1234;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        fork
            press(10);
            wait_ready(40, n);
        join
        repeat (8) @(negedge clk);

        // Bounce shorter than the debounce window must not complete the read.
        sw_in = 16'hBEEF;
        bus.io_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_confirm = ~btn_confirm;
            repeat (2) @(negedge clk);
        end
        btn_confirm = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_busy", {31'h0, bus.io_busy}, 32'h1);
        m_rdata = 32'h0000_BEEF;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        fork
            press(10);
            wait_ready(40, n);
        join
        repeat (8) @(negedge clk);

        // Button already held before the read: needs release and fresh press.
        btn_confirm = 1'b1;
        sw_in = 16'h5A5A;
        repeat (12) @(negedge clk);
        bus.io_read = 1'b1;
        repeat (15) @(negedge clk);
        chk("held_busy", {31'h0, bus.io_busy}, 32'h1);
        btn_confirm = 1'b0;
        repeat (10) @(negedge clk);
        sw_in = 16'h0F0F;
        repeat (3) @(negedge clk);
        m_rdata = 32'h0000_0F0F;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        fork
            press(10);
            wait_ready(40, n);
        join
        repeat (8) @(negedge clk);

        // Simultaneous read and write: write wins, read data untouched.
        m_led = 16'hFFFF;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        bus.io_read  = 1'b1;
        bus.io_write = 1'b1;
        bus.io_wdata = 32'h0000_FFFF;
        wait_ready(10, n);
        chk("simul_latency", n, 32'd1);
        @(negedge clk);
        chk("simul_no_busy", {31'h0, bus.io_busy}, 32'h0);
        chk("simul_no_wait", {31'h0, wait_led}, 32'h0);

        // Reset in the middle of a read wait.
        bus.io_read = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'h0, bus.io_busy}, 32'h1);
        rst_n = 1'b0;
        bus.io_read = 1'b0;
        #1;
        chk("arst_busy", {31'h0, bus.io_busy}, 32'h0);
        chk("arst_wait_led", {31'h0, wait_led}, 32'h0);
        chk("arst_led", {16'h0, led_out}, 32'h0);
        m_rdata = 32'h0;
        m_led   = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_ready", {31'h0, bus.io_ready}, 32'h0);

        // Back in IDLE: a write completes normally.
        m_led = 16'h00AA;
        e.rdata = m_rdata; e.led = m_led; sb_q.push_back(e);
        bus.io_write = 1'b1;
        bus.io_wdata = 32'h1234_00AA;
        wait_ready(10, n);
        chk("final_latency", n, 32'd1);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
